// File: rtl/fp_dot_acc_pkg.sv
// Shared types and constants for the streaming dot-product accumulator:
// FSM state encoding, float field positions and the tree-sizing helper.
package fp_dot_acc_pkg;

    localparam int FP_E_WIDTH    = 8;
    localparam int FP_FRAC_WIDTH = 23;
    localparam int FP_BIT_SIZE   = 1 + FP_E_WIDTH + FP_FRAC_WIDTH;

    localparam int FP_SIGN_IDX = FP_E_WIDTH + FP_FRAC_WIDTH;
    localparam int FP_EXP_MSB  = FP_SIGN_IDX - 1;
    localparam int FP_EXP_LSB  = FP_FRAC_WIDTH;
    localparam int FP_FRAC_MSB = FP_FRAC_WIDTH - 1;

    localparam logic [FP_BIT_SIZE-1:0] FP_POS_ZERO = '0;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Number of live nodes at a given level of a pairwise reduction tree.
    function automatic int lanes_at_level(input int lanes, input int level);
        return (lanes + (1 << level) - 1) >> level;
    endfunction

endpackage

// File: rtl/fp_add.sv
// Combinational IEEE-754 style adder: round-to-nearest-even, gradual underflow,
// overflow to infinity, any NaN operand or Inf-Inf yields the canonical quiet NaN.
module fp_add
    import fp_dot_acc_pkg::*;
#(
    parameter int BIT_SIZE   = FP_SIGN_IDX + 1,
    parameter int E_WIDTH    = FP_EXP_MSB - FP_EXP_LSB + 1,
    parameter int FRAC_WIDTH = FP_FRAC_MSB + 1
) (
    input  logic [BIT_SIZE-1:0] i_a,
    input  logic [BIT_SIZE-1:0] i_b,
    output logic [BIT_SIZE-1:0] o_sum
);

    localparam int WW = FRAC_WIDTH + 5;
    localparam int EW = E_WIDTH + 2;
    localparam logic [E_WIDTH-1:0] EXP_MAX = '1;
    localparam logic [BIT_SIZE-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, (FRAC_WIDTH-1)'(0)};

    logic                  w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap;
    logic [BIT_SIZE-1:0]   w_x, w_y, w_finite;
    logic                  w_x_sign, w_y_sign, w_sticky, w_round_up;
    logic [E_WIDTH-1:0]    w_x_exp, w_y_exp, w_x_eeff, w_y_eeff, w_shift;
    logic [FRAC_WIDTH:0]   w_x_man, w_y_man;
    logic [WW-1:0]         w_x_ext, w_y_ext, w_y_sh, w_sum;
    logic [WW-2:0]         w_norm;
    logic [EW-1:0]         w_exp;
    logic [FRAC_WIDTH+1:0] w_man_r;

    assign w_a_nan = (&i_a[BIT_SIZE-2:FRAC_WIDTH]) && (|i_a[FRAC_WIDTH-1:0]);
    assign w_b_nan = (&i_b[BIT_SIZE-2:FRAC_WIDTH]) && (|i_b[FRAC_WIDTH-1:0]);
    assign w_a_inf = (&i_a[BIT_SIZE-2:FRAC_WIDTH]) && !(|i_a[FRAC_WIDTH-1:0]);
    assign w_b_inf = (&i_b[BIT_SIZE-2:FRAC_WIDTH]) && !(|i_b[FRAC_WIDTH-1:0]);

    // x is always the larger magnitude, so the mantissa difference never goes negative.
    assign w_swap   = i_b[BIT_SIZE-2:0] > i_a[BIT_SIZE-2:0];
    assign w_x      = w_swap ? i_b : i_a;
    assign w_y      = w_swap ? i_a : i_b;
    assign w_x_sign = w_x[BIT_SIZE-1];
    assign w_y_sign = w_y[BIT_SIZE-1];
    assign w_x_exp  = w_x[BIT_SIZE-2:FRAC_WIDTH];
    assign w_y_exp  = w_y[BIT_SIZE-2:FRAC_WIDTH];
    assign w_x_eeff = (w_x_exp == '0) ? E_WIDTH'(1) : w_x_exp;
    assign w_y_eeff = (w_y_exp == '0) ? E_WIDTH'(1) : w_y_exp;
    assign w_x_man  = {|w_x_exp, w_x[FRAC_WIDTH-1:0]};
    assign w_y_man  = {|w_y_exp, w_y[FRAC_WIDTH-1:0]};
    assign w_shift  = w_x_eeff - w_y_eeff;

    // Working format: carry | hidden | fraction | guard | round | sticky.
    assign w_x_ext  = {1'b0, w_x_man, 3'b000};
    assign w_y_ext  = {1'b0, w_y_man, 3'b000};
    assign w_y_sh   = w_y_ext >> w_shift;
    assign w_sticky = |(w_y_ext & ~({WW{1'b1}} << w_shift));
    assign w_sum    = (w_x_sign ^ w_y_sign) ? (w_x_ext - (w_y_sh | WW'(w_sticky)))
                                            : (w_x_ext + (w_y_sh | WW'(w_sticky)));

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_exp = EW'(w_x_eeff);
        if (w_sum[WW-1]) begin
            w_norm = {w_sum[WW-1:2], |w_sum[1:0]};
            w_exp  = w_exp + EW'(1);
        end else begin
            w_norm = w_sum[WW-2:0];
            for (int i = 0; i < WW; i++) begin
                if (!w_norm[WW-2] && (w_exp > EW'(1))) begin
                    w_norm = w_norm << 1;
                    w_exp  = w_exp - EW'(1);
                end
            end
        end

        w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_man_r    = {1'b0, w_norm[WW-2:3]} + (FRAC_WIDTH+2)'(w_round_up);
        if (w_man_r[FRAC_WIDTH+1]) begin
            w_man_r = w_man_r >> 1;
            w_exp   = w_exp + EW'(1);
        end

        // A clear hidden bit after rounding means a subnormal, encoded with exponent 0.
        if (w_exp >= {2'b00, EXP_MAX}) begin
            w_finite = {w_x_sign, EXP_MAX, FRAC_WIDTH'(0)};
        end else if (w_man_r == '0) begin
            w_finite = {w_x_sign & w_y_sign, (BIT_SIZE-1)'(0)};
        end else begin
            w_finite = {w_x_sign, (w_man_r[FRAC_WIDTH] ? w_exp[E_WIDTH-1:0] : E_WIDTH'(0)),
                        w_man_r[FRAC_WIDTH-1:0]};
        end

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[BIT_SIZE-1] != i_b[BIT_SIZE-1]))) begin
            o_sum = QNAN;
        end else if (w_a_inf) begin
            o_sum = i_a;
        end else if (w_b_inf) begin
            o_sum = i_b;
        end else begin
            o_sum = w_finite;
        end
    end

endmodule

// File: rtl/fp_dot_acc_tree.sv
// Combinational left-to-right pairwise reduction of PARALLELISM float lanes;
// an odd trailing node passes straight through to the next level.
module fp_add_tree
    import fp_dot_acc_pkg::*;
#(
    parameter int BIT_SIZE    = FP_BIT_SIZE,
    parameter int E_WIDTH     = FP_E_WIDTH,
    parameter int FRAC_WIDTH  = FP_FRAC_WIDTH,
    parameter int PARALLELISM = 3
) (
    input  logic [BIT_SIZE-1:0] i_lanes [0:PARALLELISM-1],
    output logic [BIT_SIZE-1:0] o_sum
);

    localparam int LEVELS = $clog2(PARALLELISM);

    logic [BIT_SIZE-1:0] w_node [0:LEVELS][0:PARALLELISM-1];

    for (genvar g = 0; g < PARALLELISM; g++) begin : gen_leaf
        assign w_node[0][g] = i_lanes[g];
    end

    for (genvar lv = 0; lv < LEVELS; lv++) begin : gen_level
        for (genvar n = 0; n < PARALLELISM; n++) begin : gen_node
            if (n < lanes_at_level(PARALLELISM, lv + 1)) begin : gen_live
                if (2 * n + 1 < lanes_at_level(PARALLELISM, lv)) begin : gen_add
                    fp_add #(
                        .BIT_SIZE  (BIT_SIZE),
                        .E_WIDTH   (E_WIDTH),
                        .FRAC_WIDTH(FRAC_WIDTH)
                    ) u_add (
                        .i_a  (w_node[lv][2*n]),
                        .i_b  (w_node[lv][2*n+1]),
                        .o_sum(w_node[lv+1][n])
                    );
                end else begin : gen_pass
                    assign w_node[lv+1][n] = w_node[lv][2*n];
                end
            end else begin : gen_idle
                assign w_node[lv+1][n] = '0;
            end
        end
    end

    assign o_sum = w_node[LEVELS][0];

endmodule

// File: rtl/fp_dot_acc.sv
// Streaming float accumulator: sums the lanes of each beat and accumulates across beats
// up to in_last, then holds one result. FP_DOT_ACC_STATS_EN adds the out_beats counter.
module fp_dot_acc
    import fp_dot_acc_pkg::*;
#(
    parameter int BIT_SIZE    = FP_BIT_SIZE,
    parameter int E_WIDTH     = FP_E_WIDTH,
    parameter int FRAC_WIDTH  = FP_FRAC_WIDTH,
`ifdef FP_DOT_ACC_STATS_EN
    parameter int CNT_WIDTH   = 16,
`endif
    parameter int PARALLELISM = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIT_SIZE-1:0] in_data [0:PARALLELISM-1],
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    output logic [BIT_SIZE-1:0] out_data,
    output logic                out_valid,
`ifdef FP_DOT_ACC_STATS_EN
    output logic [CNT_WIDTH-1:0] out_beats,
`endif
    input  logic                out_ready
);

    state_t              r_state, w_state_next;
    logic [BIT_SIZE-1:0] r_acc, r_result, w_lane_sum, w_acc_next;
    logic                w_fire;

    fp_add_tree #(
        .BIT_SIZE   (BIT_SIZE),
        .E_WIDTH    (E_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .PARALLELISM(PARALLELISM)
    ) u_tree (
        .i_lanes(in_data),
        .o_sum  (w_lane_sum)
    );

    fp_add #(
        .BIT_SIZE  (BIT_SIZE),
        .E_WIDTH   (E_WIDTH),
        .FRAC_WIDTH(FRAC_WIDTH)
    ) u_acc_add (
        .i_a  (r_acc),
        .i_b  (w_lane_sum),
        .o_sum(w_acc_next)
    );

    // Acceptance depends on state only, so in_ready never follows out_ready combinationally.
    assign w_fire   = in_valid && (r_state == ACC);
    assign out_data = r_result;

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) w_state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = ACC;
            end
            default: w_state_next = ACC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ACC;
            r_acc    <= BIT_SIZE'(FP_POS_ZERO);
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_fire) begin
                if (in_last) begin
                    r_result <= w_acc_next;
                    r_acc    <= BIT_SIZE'(FP_POS_ZERO);
                end else begin
                    r_acc <= w_acc_next;
                end
            end
        end
    end

`ifdef FP_DOT_ACC_STATS_EN
    logic [CNT_WIDTH-1:0] r_beat_cnt, r_out_beats, w_cnt_inc;

    assign w_cnt_inc = (&r_beat_cnt) ? r_beat_cnt : r_beat_cnt + CNT_WIDTH'(1);
    assign out_beats = r_out_beats;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt  <= '0;
            r_out_beats <= '0;
        end else if (w_fire) begin
            if (in_last) begin
                r_out_beats <= w_cnt_inc;
                r_beat_cnt  <= '0;
            end else begin
                r_beat_cnt <= w_cnt_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp_dot_acc.sv
// Scoreboard bench for fp_dot_acc: directed beats push expected results into a queue,
// a negedge monitor pops and compares on every output handshake.
module tb_fp_dot_acc;

    typedef logic [31:0] word_t;
    typedef struct {
        word_t data;
        int    beats;
    } exp_t;

    localparam word_t F_0    = 32'h00000000;
    localparam word_t F_1    = 32'h3F800000;
    localparam word_t F_2    = 32'h40000000;
    localparam word_t F_3    = 32'h40400000;
    localparam word_t F_4    = 32'h40800000;
    localparam word_t F_6    = 32'h40C00000;
    localparam word_t F_10   = 32'h41200000;
    localparam word_t F_05   = 32'h3F000000;
    localparam word_t F_M1   = 32'hBF800000;
    localparam word_t F_15   = 32'h3FC00000;
    localparam word_t F_25   = 32'h40200000;
    localparam word_t F_M4   = 32'hC0800000;
    localparam word_t F_INF  = 32'h7F800000;
    localparam word_t F_TINY = 32'h33800000;
    localparam word_t F_1P   = 32'h3F800001;
    localparam word_t F_1PP  = 32'h3F800002;

    logic  clk = 1'b0;
    logic  rst;
    word_t in_data [0:2];
    logic  in_valid, in_ready, in_last;
    word_t out_data;
    logic  out_valid, out_ready;
`ifdef FP_DOT_ACC_STATS_EN
    logic [15:0] out_beats;
`endif

    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_pushed  = 0;
    int   n_results = 0;
    int   cycle     = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    fp_dot_acc dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .out_data (out_data),
        .out_valid(out_valid),
`ifdef FP_DOT_ACC_STATS_EN
        .out_beats(out_beats),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got === req) n_pass++;
        else $display("FAIL %s: got=%h required=%h (t=%0t)", name, got, req, $time);
    endtask

    task automatic expect_result(input word_t d, input int beats);
        sb_q.push_back('{data: d, beats: beats});
        n_pushed++;
    endtask

    // Holds the beat until it is accepted; returns the cycle number of the accepting edge.
    task automatic send_beat(input word_t l0, input word_t l1, input word_t l2,
                             input logic last, output int acc_cyc);
        logic ok;
        int   budget;
        in_data[0] = l0;
        in_data[1] = l1;
        in_data[2] = l2;
        in_valid   = 1'b1;
        in_last    = last;
        budget     = 0;
        acc_cyc    = -1;
        do begin
            ok = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end while (!ok && budget < 50);
        if (ok) acc_cyc = cycle;
        else begin
            n_checks++;
            $display("FAIL beat_accept_timeout: got=in_ready_low required=accepted");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_results++;
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got=%h required=no_output", out_data);
            end else begin
                mon_e = sb_q.pop_front();
                check("result_data", out_data, mon_e.data);
`ifdef FP_DOT_ACC_STATS_EN
                check("result_beats", 32'(out_beats), 32'(mon_e.beats));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int c1, c2, c3, c4;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) in_data[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'd0);
`ifdef FP_DOT_ACC_STATS_EN
        check("reset_out_beats", 32'(out_beats), 32'd0);
`endif
        out_ready = 1'b1;

        // Single beat 1+2+3, visible one cycle after acceptance.
        expect_result(F_6, 1);
        send_beat(F_1, F_2, F_3, 1'b1, c1);
        @(negedge clk);
        check("latency_out_valid", 32'(out_valid), 32'd1);
        check("latency_in_ready", 32'(in_ready), 32'd0);

        // Two beats accumulate to 10.0.
        send_beat(F_1, F_2, F_3, 1'b0, c1);
        expect_result(F_10, 2);
        send_beat(F_1, F_1, F_2, 1'b1, c2);
        idle(2);

        // Stall: result held, next packet presented and ignored until release.
        out_ready = 1'b0;
        expect_result(F_6, 1);
        send_beat(F_1, F_2, F_3, 1'b1, c1);
        in_data[0] = F_05;
        in_data[1] = F_05;
        in_data[2] = F_0;
        in_valid   = 1'b1;
        in_last    = 1'b1;
        expect_result(F_1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", out_data, F_6);
            check("stall_in_ready", 32'(in_ready), 32'd0);
`ifdef FP_DOT_ACC_STATS_EN
            check("stall_out_beats", 32'(out_beats), 32'd1);
`endif
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        send_beat(F_05, F_05, F_0, 1'b1, c1);
        idle(2);

        // Reset mid-packet discards the partial sum.
        send_beat(F_1, F_2, F_3, 1'b0, c1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        expect_result(F_1, 1);
        send_beat(F_05, F_05, F_0, 1'b1, c1);
        idle(2);

        // Reset in HOLD drops the pending result.
        out_ready = 1'b0;
        send_beat(F_3, F_0, F_0, 1'b1, c1);
        @(negedge clk);
        check("hold_before_rst", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("holdrst_out_valid", 32'(out_valid), 32'd0);
        check("holdrst_out_data", out_data, 32'd0);
        check("holdrst_in_ready", 32'(in_ready), 32'd1);

        // Cancellation gives +0.
        expect_result(F_0, 1);
        send_beat(F_1, F_M1, F_0, 1'b1, c1);

        // Back-to-back single-beat packets: one result every 2 cycles.
        expect_result(F_3, 1);
        send_beat(F_1, F_1, F_1, 1'b1, c1);
        expect_result(F_6, 1);
        send_beat(F_2, F_2, F_2, 1'b1, c2);
        expect_result(F_0, 1);
        send_beat(F_15, F_25, F_M4, 1'b1, c3);
        check("b2b_gap_1", 32'(c2 - c1), 32'd2);
        check("b2b_gap_2", 32'(c3 - c2), 32'd2);

        // Infinity propagation, round-to-even ties and fixed summation order.
        expect_result(F_INF, 1);
        send_beat(F_INF, F_1, F_0, 1'b1, c1);
        expect_result(F_1, 1);
        send_beat(F_1, F_TINY, F_0, 1'b1, c1);
        expect_result(F_1PP, 1);
        send_beat(F_1P, F_TINY, F_0, 1'b1, c1);
        expect_result(F_1, 1);
        send_beat(F_1, F_TINY, F_TINY, 1'b1, c1);

        // Four-beat packet of {1,0,0}, accepted on consecutive cycles.
        send_beat(F_1, F_0, F_0, 1'b0, c1);
        send_beat(F_1, F_0, F_0, 1'b0, c2);
        send_beat(F_1, F_0, F_0, 1'b0, c3);
        expect_result(F_4, 4);
        send_beat(F_1, F_0, F_0, 1'b1, c4);
        check("multi_beat_span", 32'(c4 - c1), 32'd3);

        idle(4);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("result_count", 32'(n_results), 32'(n_pushed));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
